// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-wide single-port
// data memory, with sub-word loads extracted and SB/SH done as read-modify-write.
module load_store_unit #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic        mem_r_enable,
    output logic        mem_w_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [15:0] wdata_q;

    logic        f3_bad;
    logic        misaligned;
    logic        out_of_range;
    logic        acc_err;
    logic        is_sw;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // Request legality is decided from the live inputs in the accept cycle.
    always_comb begin
        f3_bad     = 1'b0;
        misaligned = 1'b0;
        unique case (1'b1)
            req_we:  f3_bad = (req_funct3 >= 3'd3);
            !req_we: f3_bad = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
        endcase
        case (req_funct3[1:0])
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS_W;
        acc_err      = f3_bad | misaligned | out_of_range;
        is_sw        = req_we && (req_funct3[1:0] == 2'd2);
    end

    always_comb begin
        rd_byte  = mem_rdata[{off_q, 3'b000} +: 8];
        rd_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val = mem_rdata;
        case (f3_q)
            3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_val = {24'h0, rd_byte};
            3'd5:    load_val = {16'h0, rd_half};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        merge_val = mem_rdata;
        if (f3_q[1:0] == 2'd1)
            merge_val[{off_q[1], 4'b0000} +: 16] = wdata_q;
        else
            merge_val[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            off_q        <= 2'b00;
            f3_q         <= 3'b000;
            we_q         <= 1'b0;
            wdata_q      <= 16'h0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_error   <= 1'b0;
            resp_rdata   <= 32'h0;
            mem_addr     <= 32'h0;
            mem_r_enable <= 1'b0;
            mem_w_enable <= 1'b0;
            mem_wdata    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        off_q     <= req_addr[1:0];
                        f3_q      <= req_funct3;
                        we_q      <= req_we;
                        wdata_q   <= req_wdata[15:0];
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        if (acc_err) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end else if (is_sw) begin
                            mem_w_enable <= 1'b1;
                            mem_wdata    <= req_wdata;
                            state        <= WR;
                        end else begin
                            mem_r_enable <= 1'b1;
                            state        <= RD;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD: begin
                    mem_r_enable <= 1'b0;
                    state        <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (we_q) begin
                        mem_wdata    <= merge_val;
                        mem_w_enable <= 1'b1;
                        state        <= WR;
                    end else begin
                        resp_rdata <= load_val;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        state      <= RESP;
                    end
                end
                WR: begin
                    mem_w_enable <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_error   <= 1'b0;
                    resp_rdata   <= 32'h0;
                    state        <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    mem_r_enable <= 1'b0;
                    mem_w_enable <= 1'b0;
                    resp_valid   <= 1'b0;
                    req_ready    <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic checked
// against an arithmetic reference memory and per-cycle strobe/response checks.
module tb_load_store_unit;

    localparam int MEM_WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_addr     (mem_addr),
        .mem_r_enable (mem_r_enable),
        .mem_w_enable (mem_w_enable),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory device: registered read, write commits on the edge.
    always @(posedge clk) begin
        if (mem_w_enable)
            mem[mem_addr[13:2]] <= mem_wdata;
        if (mem_r_enable)
            mem_rdata <= mem[mem_addr[13:2]];
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Reference semantics of one access; updates ref_mem for stores.
    task automatic model(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd,
                         output int lat, output int nr, output int nw,
                         output logic [31:0] word);
        int unsigned wi, sh, hs, bv, hv, sz;
        logic [31:0] w;
        wi  = a >> 2;
        sz  = f3 % 4;
        sh  = (a % 4) * 8;
        hs  = ((a % 4) / 2) * 16;
        w   = (wi < MEM_WORDS) ? ref_mem[wi] : 32'h0;
        bv  = (w >> sh) % 256;
        hv  = (w >> hs) % 65536;
        err = 1'b0;
        if (we && f3 >= 3) err = 1'b1;
        if (!we && (f3 == 3 || f3 >= 6)) err = 1'b1;
        if (sz == 1 && (a % 2) != 0) err = 1'b1;
        if (sz == 2 && (a % 4) != 0) err = 1'b1;
        if (wi >= MEM_WORDS) err = 1'b1;
        rd   = 32'h0;
        word = 32'h0;
        if (err) begin
            lat = 1; nr = 0; nw = 0;
        end else if (!we) begin
            lat = 3; nr = 1; nw = 0;
            case (f3)
                3'd0: rd = (bv >= 128) ? bv - 256 : bv;
                3'd1: rd = (hv >= 32768) ? hv - 65536 : hv;
                3'd4: rd = bv;
                3'd5: rd = hv;
                default: rd = w;
            endcase
        end else begin
            if (f3 == 3'd2) begin
                lat = 2; nr = 0; nw = 1;
                word = wd;
            end else begin
                lat = 4; nr = 1; nw = 1;
                if (f3 == 3'd0)
                    word = w - (bv << sh) + ((wd % 256) << sh);
                else
                    word = w - (hv << hs) + ((wd % 65536) << hs);
            end
            ref_mem[wi] = word;
        end
    endtask

    // Issue one request from a negedge and follow it cycle by cycle.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got);
        logic        e_err;
        logic [31:0] e_rd, e_word;
        int          lat, nr, nw, cr, cw, t;
        got = 32'h0;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk1("ready_wait", req_ready, 1'b1);
            return;
        end
        model(we, f3, a, wd, e_err, e_rd, lat, nr, nw, e_word);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        cr = 0;
        cw = 0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            chk1("strobe_excl", mem_r_enable & mem_w_enable, 1'b0);
            if (mem_r_enable) begin
                cr++;
                chk("rd_addr", mem_addr, {a[31:2], 2'b00});
            end
            if (mem_w_enable) begin
                cw++;
                chk("wr_addr", mem_addr, {a[31:2], 2'b00});
                chk("wr_data", mem_wdata, e_word);
            end
            chk1("resp_valid", resp_valid, k == lat);
            if (resp_valid) begin
                chk1("resp_error", resp_error, e_err);
                chk("resp_rdata", resp_rdata, e_rd);
                got = resp_rdata;
            end
        end
        chk("rd_strobes", 32'(cr), 32'(nr));
        chk("wr_strobes", 32'(cw), 32'(nw));
    endtask

    logic [31:0] got;
    logic [31:0] q_exp [$];
    logic        b_err;
    logic [31:0] b_rd, b_word;
    int          b_lat, b_nr, b_nw;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[128] = 32'h80FF7F01; ref_mem[128] = 32'h80FF7F01;
        mem[192] = 32'h11223344; ref_mem[192] = 32'h11223344;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk1("rst_ready", req_ready, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_error", resp_error, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk1("rst_ren", mem_r_enable, 1'b0);
        chk1("rst_wen", mem_w_enable, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk1("ready_after_rst", req_ready, 1'b1);
        @(negedge clk);

        do_req(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, got);
        do_req(1'b0, 3'd2, 32'h100, 32'h0, got);
        chk("lw_100", got, 32'hDEADBEEF);

        do_req(1'b0, 3'd0, 32'h203, 32'h0, got);
        chk("lb_203", got, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h203, 32'h0, got);
        chk("lbu_203", got, 32'h00000080);
        do_req(1'b0, 3'd1, 32'h202, 32'h0, got);
        chk("lh_202", got, 32'hFFFF80FF);
        do_req(1'b0, 3'd5, 32'h202, 32'h0, got);
        chk("lhu_202", got, 32'h000080FF);
        do_req(1'b0, 3'd0, 32'h200, 32'h0, got);
        chk("lb_200", got, 32'h00000001);

        do_req(1'b1, 3'd0, 32'h301, 32'h000000AB, got);
        do_req(1'b1, 3'd1, 32'h302, 32'h0000CDEF, got);
        chk("rmw_mem_300", mem[192], 32'hCDEFAB44);
        do_req(1'b0, 3'd2, 32'h300, 32'h0, got);
        chk("lw_300", got, 32'hCDEFAB44);

        do_req(1'b0, 3'd2, 32'h102, 32'h0, got);
        do_req(1'b0, 3'd1, 32'h101, 32'h0, got);
        do_req(1'b0, 3'd3, 32'h100, 32'h0, got);
        do_req(1'b1, 3'd2, 32'h4000, 32'h12345678, got);
        chk("err_mem_100", mem[64], 32'hDEADBEEF);
        chk("err_mem_0", mem[0], ref_mem[0]);

        // Abort an SB while its write strobe is up.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h381;
        req_wdata  = 32'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk1("abort_in_wr", mem_w_enable, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("abort_wen", mem_w_enable, 1'b0);
        chk1("abort_ren", mem_r_enable, 1'b0);
        chk1("abort_ready", req_ready, 1'b0);
        chk("abort_addr", mem_addr, 32'h0);
        chk("abort_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk1("abort_ready_rel", req_ready, 1'b1);
        chk1("abort_no_resp", resp_valid, 1'b0);
        @(negedge clk);
        chk1("abort_no_resp2", resp_valid, 1'b0);
        chk("abort_word", mem[224], ref_mem[224]);

        // Back-to-back loads with req_valid held high.
        begin
            int n, nresp, last;
            logic [31:0] baddr [3];
            baddr[0] = 32'h100;
            baddr[1] = 32'h200;
            baddr[2] = 32'h300;
            n = 0;
            nresp = 0;
            last = -1;
            for (int c = 0; c < 40 && nresp < 3; c++) begin
                chk1("b2b_excl", mem_r_enable & mem_w_enable, 1'b0);
                if (resp_valid) begin
                    chk1("b2b_err", resp_error, 1'b0);
                    chk("b2b_rdata", resp_rdata, q_exp.pop_front());
                    nresp++;
                end
                if (req_ready && n < 3) begin
                    if (last >= 0)
                        chk("b2b_spacing", 32'(c - last), 32'd4);
                    last       = c;
                    req_valid  = 1'b1;
                    req_we     = 1'b0;
                    req_funct3 = 3'd2;
                    req_addr   = baddr[n];
                    model(1'b0, 3'd2, baddr[n], 32'h0, b_err, b_rd,
                          b_lat, b_nr, b_nw, b_word);
                    q_exp.push_back(b_rd);
                    n++;
                end
                @(posedge clk);
                #1 if (n == 3) req_valid = 1'b0;
                @(negedge clk);
            end
            chk("b2b_count", 32'(nresp), 32'd3);
        end

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 63) * 4) + $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0)
                a = $urandom;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   a, $urandom, got);
        end
        for (int i = 0; i < 64; i++)
            chk("final_mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the core's data-memory interface. Drives the word-wide, single-port data memory: one-cycle read enable, registered read data, no byte enables.
- Takes one load/store request at a time from the execute stage, using RV32I funct3 encoding.
- Loads: issues the word read, then aligns and sign/zero-extends the selected byte or halfword.
- Stores: SW writes directly; SB/SH use read-modify-write.
- Returns a one-cycle completion pulse with result or error.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in the data memory. Word index addr[31:2] >= MEM_WORDS is an access error.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  LSU can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5 / SB=0 SH=1 SW=2
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low byte/halfword used for SB/SH)
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result, valid with resp_valid
- resp_error  output  1  misaligned, illegal funct3 or out-of-range access, valid with resp_valid
- mem_addr  output  32  word-aligned byte address {addr[31:2],2'b00}
- mem_r_enable  output  1  read strobe; data appears on mem_rdata the following cycle
- mem_w_enable  output  1  write strobe; memory commits on the sampling edge
- mem_wdata  output  32  write word
- mem_rdata  input  32  read word from memory

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - Outputs go to: req_ready=0 while rst_n low, resp_valid=0, resp_error=0, resp_rdata=0, mem_r_enable=0, mem_w_enable=0, mem_addr=0, mem_wdata=0.
  - An in-flight access is abandoned, even mid-RMW. No response is produced. A strobe not yet sampled is dropped.
  - req_ready=1 in the first cycle after release.
- States: IDLE, RD, RD_WAIT, WR, RESP. Encoding is free.
- IDLE: req_ready=1. Accept on req_valid && req_ready. Latch addr, funct3, we and wdata into internal registers; later inputs are ignored.
- Error check at accept. Any of the following sets err and goes directly to RESP with no memory strobe:
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - load funct3 in {3,6,7}
  - store funct3 >= 3
  - addr[31:2] >= MEM_WORDS
- Otherwise:
  - load -> RD
  - SW -> WR
  - SB/SH -> RD
- RD: mem_r_enable=1, mem_addr=latched word address. Always -> RD_WAIT.
- RD_WAIT: mem_r_enable=0; mem_rdata is valid this cycle.
  - Load: capture the extracted result into resp_rdata -> RESP.
  - Store: merge into the write-word register -> WR.
- Little-endian extraction:
  - LB/LBU: byte lane addr[1:0], sign/zero extended.
  - LH/LHU: lane addr[1] (bits 15:0 or 31:16), sign/zero extended.
  - LW: full word.
- Merge:
  - SB: replace byte lane addr[1:0] with wdata[7:0].
  - SH: replace halfword lane addr[1] with wdata[15:0].
  - Other bytes keep the read value.
- WR: mem_w_enable=1; mem_wdata = merged word (SB/SH) or latched wdata (SW). -> RESP.
- RESP: resp_valid=1 for exactly one cycle, with resp_error=err. -> IDLE.
  - No response backpressure.
  - resp_rdata holds its last load value until the next load completes; it is 0 after an errored or store response.
- mem_r_enable and mem_w_enable are never high together. Both are 0 outside RD and WR.
- Latency, counted as cycles from the accept edge to the resp_valid cycle:
  - error: 1
  - SW: 2
  - load: 3
  - SB/SH: 4
- Back-to-back: the next request can be accepted in the cycle after RESP (IDLE).

Test Plan:
- Reset, then SW addr=0x100 wdata=0xDEADBEEF, then LW 0x100 -> mem_w_enable pulse with mem_addr=0x100; resp_valid 2 cycles after SW accept; LW resp_rdata=0xDEADBEEF, 3 cycles after accept, resp_error=0.
- Word 0x200 preloaded 0x80FF7F01; LB@0x203, LBU@0x203, LH@0x202, LHU@0x202, LB@0x200 -> 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF, 0x00000001.
- Word 0x300=0x11223344; SB 0x301 wdata=0xAB, then SH 0x302 wdata=0xCDEF -> exactly one RD and one WR strobe per store, 4-cycle latency; final word 0xCDEFAB44.
- LW 0x102, LH 0x101, load funct3=3, SW addr=0x4000 (MEM_WORDS=4096) -> each gives resp_error=1 one cycle after accept; no mem strobe asserted; memory contents unchanged.
- Drop rst_n during the WR state of an SB -> mem_w_enable falls asynchronously; no resp_valid; req_ready=1 one cycle after release; target word unchanged.
- req_valid held high for 3 back-to-back LWs -> accepts only in IDLE; req_ready low in RD/RD_WAIT/RESP; 3 responses in order, one accept per 4 cycles.
